uart_tx_scheduler: RTL



---
 rtl/uart_sched_pkg.sv | 7 +
 rtl/uart_tx_scheduler_fifo.sv | 38 +++
 rtl/uart_tx_scheduler.sv | 64 ++++++
 3 files changed

// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared port ids and scheduler state encoding
package uart_sched_pkg;
  localparam logic [1:0] PORT_TX = 2'b01;
  localparam logic [1:0] PORT_CTRL = 2'b10;
  localparam logic [1:0] PORT_CLR = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'b00, SEND = 2'b01, WAIT = 2'b10} state_t;
endpackage

// File: rtl/uart_tx_scheduler_fifo.sv
// tx_fifo: show-ahead synchronous byte FIFO, drops pushes while full
module tx_fifo #(
  parameter int AW = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  logic [7:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = cnt == DEPTH;
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: queues PicoBlaze bytes and alarm codes for the UART transmitter
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter logic [7:0] ALARM_CODE = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] id,
  input  logic [7:0] out_processor,
  input  logic       write_strobe,
  input  logic       alarm,
  input  logic       stop,
  input  logic       tx_done_tick,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow
);
  state_t state;
  logic alarm_q, alarm_pending;
  logic push, clr, take_alarm, pop;
  logic [7:0] head;
  logic unused_id;
  assign unused_id = ^id[7:2];
  assign push = write_strobe && id[1:0] == PORT_TX;
  assign clr = write_strobe && id[1:0] == PORT_CLR && out_processor[0];
  assign take_alarm = state == IDLE && alarm_pending;
  assign pop = state == IDLE && !alarm_pending && !fifo_empty && !stop;
  tx_fifo #(.AW(FIFO_DEPTH_LOG2)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(out_processor),
    .dout(head),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      tx_start <= 1'b0;
      tx_data <= 8'h00;
      busy <= 1'b0;
      overflow <= 1'b0;
      alarm_q <= 1'b0;
      alarm_pending <= 1'b0;
    end else begin
      alarm_q <= alarm;
      alarm_pending <= (alarm && !alarm_q) || (alarm_pending && !take_alarm);
      overflow <= (push && fifo_full) || (overflow && !clr);
      tx_start <= take_alarm || pop;
      tx_data <= take_alarm ? ALARM_CODE : pop ? head : tx_data;
      busy <= take_alarm || pop || state == SEND || (state == WAIT && !tx_done_tick);
      state <= (take_alarm || pop) ? SEND :
               state == SEND ? WAIT :
               (state == WAIT && tx_done_tick) ? IDLE : state;
    end
  end
endmodule
